// File: rtl/screen_capture_if.sv
// LED-matrix serial interface: row/column shift clocks, serial data,
// column latch enable and active-low output enable.
interface screen_capture_if;
    logic rclk;
    logic rsdi;
    logic oeb;
    logic csdi;
    logic cclk;
    logic le;

    modport master (output rclk, rsdi, oeb, csdi, cclk, le);
    modport slave  (input  rclk, rsdi, oeb, csdi, cclk, le);
endinterface

// File: rtl/screen_capture.sv
// Receiving end of the LED-matrix serial interface. Synchronizes the
// protocol lines, edge-detects them and rebuilds a 16x16 frame buffer.
module screen_capture #(
    parameter int unsigned SYNC = 2
) (
    input  logic               clk,
    input  logic               reset,
    screen_capture_if.slave    led,
    input  logic [3:0]         rd_row,
    output logic [15:0]        rd_data,
    output logic               row_strobe,
    output logic [3:0]         row_idx,
    output logic               frame_done,
    output logic [7:0]         frame_count,
    output logic               err,
    input  logic               err_clr
);

    // Synchronizer bit order: {le, cclk, csdi, oeb, rsdi, rclk}.
    // oeb idles high, so it resets to 1 to avoid a spurious falling edge.
    localparam logic [5:0] SYNC_RST = 6'b00_0100;
    // Edge-history order: {le, cclk, oeb, rclk}.
    localparam logic [3:0] PREV_RST = 4'b0010;

    logic [5:0]  sync_q [SYNC];
    logic [5:0]  sync_d [SYNC];
    logic [3:0]  prev_q, prev_d;

    logic [15:0] col_sr_q, col_sr_d;
    logic [15:0] col_lat_q, col_lat_d;
    logic [15:0] row_sr_q, row_sr_d;
    logic [15:0] frame_q [16];
    logic [15:0] frame_d [16];
    logic [15:0] rd_data_q, rd_data_d;
    logic        row_strobe_q, row_strobe_d;
    logic        frame_done_q, frame_done_d;
    logic [3:0]  row_idx_q, row_idx_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        err_q, err_d;

    logic [5:0]  sync_out;
    logic        rclk_s, rsdi_s, oeb_s, csdi_s, cclk_s, le_s;
    logic        rclk_rise, oeb_fall, cclk_rise, le_rise;
    logic        row_onehot;
    logic [3:0]  row_hit;

    assign sync_out  = sync_q[SYNC-1];
    assign rclk_s    = sync_out[0];
    assign rsdi_s    = sync_out[1];
    assign oeb_s     = sync_out[2];
    assign csdi_s    = sync_out[3];
    assign cclk_s    = sync_out[4];
    assign le_s      = sync_out[5];

    assign rclk_rise = rclk_s & ~prev_q[0];
    assign oeb_fall  = ~oeb_s & prev_q[1];
    assign cclk_rise = cclk_s & ~prev_q[2];
    assign le_rise   = le_s & ~prev_q[3];

    // Synchronizer chain and edge-history next state.
    always_comb begin
        sync_d[0] = {led.le, led.cclk, led.csdi, led.oeb, led.rsdi, led.rclk};
        for (int unsigned i = 1; i < SYNC; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = {le_s, cclk_s, oeb_s, rclk_s};
    end

    // Same-cycle events chain shift -> latch -> commit by feeding each
    // stage the already-updated value of the previous one.
    always_comb begin
        col_sr_d = col_sr_q;
        if (cclk_rise) begin
            col_sr_d = {col_sr_q[14:0], csdi_s};
        end
        col_lat_d = col_lat_q;
        if (le_rise) begin
            col_lat_d = col_sr_d;
        end
        row_sr_d = row_sr_q;
        if (rclk_rise) begin
            row_sr_d = {row_sr_q[14:0], rsdi_s};
        end
    end

    // One-hot check and encode of the row register used by a commit.
    always_comb begin
        row_onehot = (row_sr_d != '0) && ((row_sr_d & (row_sr_d - 16'd1)) == '0);
        row_hit    = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (row_sr_d[i]) begin
                row_hit = i[3:0];
            end
        end
    end

    // Commit, status and read-port next state.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            frame_d[i] = frame_q[i];
        end
        row_strobe_d  = 1'b0;
        frame_done_d  = 1'b0;
        row_idx_d     = row_idx_q;
        frame_count_d = frame_count_q;
        err_d         = err_q;
        // Read uses the pre-commit buffer contents.
        rd_data_d     = frame_q[rd_row];
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (oeb_fall) begin
            if (row_onehot) begin
                frame_d[row_hit] = col_lat_d;
                row_idx_d        = row_hit;
                row_strobe_d     = 1'b1;
                if (row_hit == 4'd15) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC; i++) begin
                sync_q[i] <= SYNC_RST;
            end
            prev_q <= PREV_RST;
            col_sr_q      <= '0;
            col_lat_q     <= '0;
            row_sr_q      <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                frame_q[i] <= '0;
            end
            rd_data_q     <= '0;
            row_strobe_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            row_idx_q     <= '0;
            frame_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SYNC; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q <= prev_d;
            col_sr_q      <= col_sr_d;
            col_lat_q     <= col_lat_d;
            row_sr_q      <= row_sr_d;
            for (int unsigned i = 0; i < 16; i++) begin
                frame_q[i] <= frame_d[i];
            end
            rd_data_q     <= rd_data_d;
            row_strobe_q  <= row_strobe_d;
            frame_done_q  <= frame_done_d;
            row_idx_q     <= row_idx_d;
            frame_count_q <= frame_count_d;
            err_q         <= err_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign row_strobe  = row_strobe_q;
    assign frame_done  = frame_done_q;
    assign row_idx     = row_idx_q;
    assign frame_count = frame_count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_screen_capture.sv
// Self-checking bench for screen_capture: drives the LED serial protocol
// and compares against a frame-level reference model.
module tb_screen_capture;

    localparam int unsigned SYNC = 2;
    localparam int unsigned HOLD = SYNC + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_row;
    logic [15:0] rd_data;
    logic        row_strobe;
    logic [3:0]  row_idx;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        err;
    logic        err_clr;

    screen_capture_if bus();

    screen_capture #(.SYNC(SYNC)) dut (
        .clk         (clk),
        .reset       (reset),
        .led         (bus),
        .rd_row      (rd_row),
        .rd_data     (rd_data),
        .row_strobe  (row_strobe),
        .row_idx     (row_idx),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err         (err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [15:0] m_frame [16];
    logic [15:0] m_col_sr, m_col_lat, m_row_sr;
    logic        m_err;
    int          m_count;
    int          m_last;
    logic [15:0] rb [16];

    // Pulse monitor.
    int   mon_strobe = 0;
    int   mon_done = 0;
    int   mon_done_bad = 0;
    int   mon_b2b = 0;
    int   mon_last_idx = 0;
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (row_strobe) begin
            mon_strobe++;
            mon_last_idx = int'(row_idx);
        end
        if (frame_done) begin
            mon_done++;
            if (!row_strobe || row_idx != 4'd15) mon_done_bad++;
        end
        if ((row_strobe || frame_done) && prev_pulse) mon_b2b++;
        prev_pulse = row_strobe || frame_done;
    end

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_frame[i] = '0;
        m_col_sr = '0; m_col_lat = '0; m_row_sr = '0;
        m_err = 1'b0; m_count = 0;
    endfunction

    function automatic void m_shift_col(input logic b);
        m_col_sr = 16'((32'(m_col_sr) * 2 + 32'(b)) % 65536);
    endfunction

    function automatic void m_shift_row(input logic b);
        m_row_sr = 16'((32'(m_row_sr) * 2 + 32'(b)) % 65536);
    endfunction

    function automatic void m_commit();
        if ($countones(m_row_sr) == 1) begin
            for (int i = 0; i < 16; i++) if (m_row_sr == 16'(1 << i)) m_last = i;
            m_frame[m_last] = m_col_lat;
            if (m_last == 15) m_count = (m_count + 1) % 256;
        end else begin
            m_err = 1'b1;
        end
    endfunction

    task automatic hold();
        repeat (HOLD) @(posedge clk);
        #1;
    endtask

    task automatic col_bit(input logic b);
        bus.csdi = b; hold();
        bus.cclk = 1'b1; m_shift_col(b); hold();
        bus.cclk = 1'b0;
    endtask

    task automatic load_cols(input logic [15:0] p);
        for (int i = 15; i >= 0; i--) col_bit(p[i]);
        hold();
    endtask

    task automatic pulse_le();
        bus.le = 1'b1; m_col_lat = m_col_sr; hold();
        bus.le = 1'b0; hold();
    endtask

    task automatic row_bit(input logic b);
        bus.rsdi = b; hold();
        bus.rclk = 1'b1; m_shift_row(b); hold();
        bus.rclk = 1'b0; hold();
    endtask

    task automatic commit();
        bus.oeb = 1'b0; m_commit(); hold();
        bus.oeb = 1'b1; hold();
    endtask

    // Row shift and commit on the same edge: one row in three hold periods.
    task automatic fast_row(input logic b);
        bus.rsdi = b; hold();
        bus.rclk = 1'b1; bus.oeb = 1'b0; m_shift_row(b); m_commit(); hold();
        bus.rclk = 1'b0; bus.oeb = 1'b1; hold();
    endtask

    task automatic clear_rows();
        for (int i = 0; i < 17 && m_row_sr != '0; i++) row_bit(1'b0);
    endtask

    task automatic read_all();
        for (int r = 0; r < 16; r++) begin
            rd_row = 4'(r);
            @(posedge clk); #1;
            rb[r] = rd_data;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.rclk = 1'b0; bus.rsdi = 1'b0; bus.oeb = 1'b1;
        bus.csdi = 1'b0; bus.cclk = 1'b0; bus.le = 1'b0;
        err_clr = 1'b0; rd_row = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        hold();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (row_strobe !== 1'b0 || frame_done !== 1'b0 || row_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_pulses: strobe=%b done=%b idx=%0d, want 0 0 0", row_strobe, frame_done, row_idx);
        end
        for (int r = 0; r < 16; r++) begin
            rd_row = 4'(r);
            @(posedge clk); #1;
            n_checks++;
            if (rd_data !== 16'h0000 || err !== 1'b0 || frame_count !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_row%0d: data=%h err=%b cnt=%0d, want 0000 0 0", r, rd_data, err, frame_count);
            end
        end
    endtask

    task automatic test_single_row();
        int s0 = mon_strobe;
        load_cols(16'hA5C3);
        pulse_le();
        row_bit(1'b1);
        commit();
        n_checks++;
        if (mon_strobe - s0 !== 1 || mon_last_idx !== 0) begin
            n_fail++;
            $display("FAIL single_strobe: strobes=%0d idx=%0d, want 1 0", mon_strobe - s0, mon_last_idx);
        end
        rd_row = 4'd0;
        @(posedge clk); #1;
        n_checks++;
        if (rd_data !== 16'hA5C3 || rd_data !== m_frame[0]) begin
            n_fail++;
            $display("FAIL single_data: got %h, want a5c3", rd_data);
        end
    endtask

    task automatic test_full_frame();
        int d0;
        do_reset();
        for (int r = 0; r < 16; r++) begin
            d0 = mon_done;
            load_cols(16'(32'h1111 * r));
            pulse_le();
            row_bit(r == 0);
            commit();
            n_checks++;
            if (mon_done - d0 !== (r == 15 ? 1 : 0) || mon_last_idx !== r) begin
                n_fail++;
                $display("FAIL frame_row%0d: done_pulses=%0d idx=%0d", r, mon_done - d0, mon_last_idx);
            end
        end
        n_checks++;
        if (frame_count !== 8'd1 || frame_count !== 8'(m_count)) begin
            n_fail++;
            $display("FAIL frame_count: got %0d, want 1", frame_count);
        end
        read_all();
        for (int r = 0; r < 16; r++) begin
            n_checks++;
            if (rb[r] !== 16'(32'h1111 * r)) begin
                n_fail++;
                $display("FAIL frame_read%0d: got %h, want %h", r, rb[r], 16'(32'h1111 * r));
            end
        end
    endtask

    task automatic test_wrap();
        int d0 = mon_done;
        int s0 = mon_strobe;
        for (int f = 0; f < 255; f++) begin
            for (int r = 0; r < 16; r++) fast_row(r == 0);
        end
        n_checks++;
        if (frame_count !== 8'd0 || frame_count !== 8'(m_count) || mon_done - d0 !== 255
            || mon_strobe - s0 !== 255 * 16) begin
            n_fail++;
            $display("FAIL wrap: cnt=%0d done=%0d strobes=%0d, want 0 255 4080",
                     frame_count, mon_done - d0, mon_strobe - s0);
        end
        n_checks++;
        if (mon_done_bad !== 0 || mon_b2b !== 0) begin
            n_fail++;
            $display("FAIL pulse_shape: bad_done=%0d back_to_back=%0d, want 0 0", mon_done_bad, mon_b2b);
        end
    endtask

    task automatic test_random_rows();
        int k, s0;
        logic [15:0] p;
        for (int it = 0; it < 8; it++) begin
            clear_rows();
            k = int'($urandom_range(0, 15));
            p = 16'($urandom);
            load_cols(p);
            pulse_le();
            row_bit(1'b1);
            for (int j = 0; j < k; j++) row_bit(1'b0);
            s0 = mon_strobe;
            commit();
            rd_row = 4'(k);
            @(posedge clk); #1;
            n_checks++;
            if (mon_strobe - s0 !== 1 || mon_last_idx !== k || rd_data !== m_frame[k] || err !== m_err) begin
                n_fail++;
                $display("FAIL random_row%0d: strobes=%0d idx=%0d data=%h err=%b, want 1 %0d %h %b",
                         it, mon_strobe - s0, mon_last_idx, rd_data, err, k, m_frame[k], m_err);
            end
        end
    endtask

    task automatic test_errors();
        int s0;
        clear_rows();
        row_bit(1'b1);
        row_bit(1'b1);
        s0 = mon_strobe;
        commit();
        n_checks++;
        if (err !== 1'b1 || mon_strobe - s0 !== 0) begin
            n_fail++;
            $display("FAIL err_multi: err=%b strobes=%0d, want 1 0", err, mon_strobe - s0);
        end
        read_all();
        for (int r = 0; r < 16; r++) begin
            n_checks++;
            if (rb[r] !== m_frame[r]) begin
                n_fail++;
                $display("FAIL err_frame%0d: got %h, want %h", r, rb[r], m_frame[r]);
            end
        end
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0; m_err = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clr: err=%b, want 0", err);
        end
        clear_rows();
        commit();
        n_checks++;
        if (err !== 1'b1 || m_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_zero: err=%b, want 1", err);
        end
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0; m_err = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [15:0] p;
        clear_rows();
        row_bit(1'b1);
        for (int i = 0; i < 15; i++) col_bit(1'b0);
        bus.csdi = 1'b1; hold();
        bus.cclk = 1'b1; bus.le = 1'b1; m_shift_col(1'b1); m_col_lat = m_col_sr; hold();
        bus.cclk = 1'b0; bus.le = 1'b0; hold();
        bus.rsdi = 1'b0; hold();
        bus.rclk = 1'b1; bus.oeb = 1'b0; m_shift_row(1'b0); m_commit(); hold();
        bus.rclk = 1'b0; bus.oeb = 1'b1; hold();
        rd_row = 4'd1;
        @(posedge clk); #1;
        n_checks++;
        if (mon_last_idx !== 1 || rd_data !== 16'h0001 || rd_data !== m_frame[1]) begin
            n_fail++;
            $display("FAIL simul_shift: idx=%0d data=%h, want 1 0001", mon_last_idx, rd_data);
        end
        p = 16'($urandom);
        load_cols(p);
        bus.le = 1'b1; bus.oeb = 1'b0; m_col_lat = m_col_sr; m_commit(); hold();
        bus.le = 1'b0; bus.oeb = 1'b1; hold();
        @(posedge clk); #1;
        n_checks++;
        if (rd_data !== p || rd_data !== m_frame[1]) begin
            n_fail++;
            $display("FAIL simul_latch: data=%h, want %h", rd_data, p);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            load_cols(16'($urandom));
            pulse_le();
            row_bit(r == 0);
            commit();
        end
        reset = 1'b0;
        #2;
        n_checks++;
        if (rd_data !== 16'h0000 || frame_count !== 8'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: data=%h cnt=%0d err=%b, want 0000 0 0", rd_data, frame_count, err);
        end
        do_reset();
        read_all();
        for (int r = 0; r < 16; r++) begin
            n_checks++;
            if (rb[r] !== 16'h0000) begin
                n_fail++;
                $display("FAIL mid_reset_row%0d: got %h, want 0000", r, rb[r]);
            end
        end
        load_cols(16'($urandom));
        pulse_le();
        d0 = mon_done;
        for (int r = 0; r < 16; r++) fast_row(r == 0);
        n_checks++;
        if (frame_count !== 8'd1 || frame_count !== 8'(m_count) || mon_done - d0 !== 1) begin
            n_fail++;
            $display("FAIL mid_reset_frame: cnt=%0d done=%0d, want 1 1", frame_count, mon_done - d0);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_full_frame();
        test_wrap();
        test_random_rows();
        test_errors();
        test_simultaneous();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
